dfp_arbiter: RTL and testbench
==============================

Name: dfp_arbiter

Overview:
- Two-client arbiter sitting directly upstream of the cacheline adapter.
- Client 0 is the I-cache fill port; client 1 is the D-cache fill/writeback port.
- Selects one 256-bit line request, registers its address/data/command, presents it on the single dfp port the adapter consumes, and routes the adapter's response back to the granted client only.
- Round-robin by default; fixed D-cache priority selectable.

Parameters:
ADDR_W  32  byte address width
LINE_W  256  cacheline width in bits
RR_EN  1  1 = round-robin between clients; 0 = client 1 (D-cache) always wins ties

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset (asserted at 0)
c0_addr  input  ADDR_W  client 0 line address
c0_read  input  1  client 0 read request, held until c0_resp
c0_write  input  1  client 0 write request, held until c0_resp
c0_wdata  input  LINE_W  client 0 write line
c0_rdata  output  LINE_W  read line to client 0
c0_resp  output  1  client 0 completion, 1-cycle pulse
c1_addr  input  ADDR_W  client 1 line address
c1_read  input  1  client 1 read request, held until c1_resp
c1_write  input  1  client 1 write request, held until c1_resp
c1_wdata  input  LINE_W  client 1 write line
c1_rdata  output  LINE_W  read line to client 1
c1_resp  output  1  client 1 completion, 1-cycle pulse
dfp_addr  output  ADDR_W  to adapter; registered
dfp_read  output  1  to adapter; registered
dfp_write  output  1  to adapter; registered
dfp_wdata  output  LINE_W  to adapter; registered
dfp_rdata  input  LINE_W  from adapter
dfp_resp  input  1  from adapter; completion pulse

Behaviour:
- Reset (rst=0, async): state=IDLE, last_grant=1 (so client 0 wins the first tie), dfp_addr/dfp_read/dfp_write/dfp_wdata=0, c0_resp=c1_resp=0.
- req0 = c0_read|c0_write; req1 = c1_read|c1_write.
- States:
  - IDLE: no dfp request driven.
  - BUSY0 / BUSY1: request of client 0 / 1 outstanding at the adapter.
  - DRAIN: one-cycle bubble after a response.
- IDLE transitions:
  - Only req0 -> BUSY0.
  - Only req1 -> BUSY1.
  - Both, RR_EN=1 -> client != last_grant.
  - Both, RR_EN=0 -> BUSY1.
  - Neither -> stay.
- On grant (same clock edge as the IDLE->BUSYx transition): latch that client's addr, read, write and wdata into the dfp_* registers; update last_grant.
  - dfp_read/dfp_write first visible the cycle after the request is seen: 1-cycle added latency.
- BUSYx:
  - dfp_* held constant; the client's inputs are not re-sampled.
  - On dfp_resp=1: cx_resp=1 combinationally in that same cycle; cx_rdata=dfp_rdata; dfp_read/dfp_write cleared at the edge; -> DRAIN.
- DRAIN: no request driven, no resp. -> IDLE unconditionally. This guarantees dfp_read/dfp_write are low for at least 2 cycles between requests, so the adapter returns to its idle state.
- c0_rdata and c1_rdata are both driven from dfp_rdata at all times; only the resp of the granted client pulses. The non-granted resp is never 1.
- Read and write asserted together by one client: illegal; both bits are forwarded unchanged; no checking.
- dfp_resp in IDLE/DRAIN (spurious): ignored, no client resp.
- A client dropping its request while granted is illegal; the registered request continues to completion and resp still pulses.
- Reset mid-BUSY: everything returns to reset values immediately; any in-flight adapter response after reset release is treated as spurious.
- Starvation bound (RR_EN=1): a waiting client is granted within one foreign transaction.

Test Plan:
- Single read: c0_read=1, c0_addr=0x0000_1040 -> dfp_read=1, dfp_addr=0x0000_1040 next cycle; adapter returns dfp_rdata=0xA5..A5 with dfp_resp -> c0_resp=1 that cycle with c0_rdata=0xA5..A5, c1_resp=0, dfp_read=0 next cycle.
- Write from client 1: c1_write=1, c1_wdata=256'h0123.., c1_addr=0x8000_0020 -> dfp_write/dfp_wdata/dfp_addr match; resp -> c1_resp pulse only; DRAIN then IDLE.
- Simultaneous requests, RR_EN=1 after reset: c0_read and c1_read both held -> client 0 served first, then client 1 with no intervening client 0 grant; 3 back-to-back pairs alternate 0,1,0,1,0,1.
- Simultaneous requests, RR_EN=0: both held -> client 1 served before client 0, repeatedly if client 1 re-requests after DRAIN.
- Async reset mid-BUSY1: drop rst for half a cycle -> dfp_read/dfp_write=0 immediately; later dfp_resp pulse produces no c0_resp/c1_resp; next request starts from IDLE, client 0 winning the tie.
- Spurious dfp_resp in IDLE -> no client resp, state remains IDLE.

Source files
------------

// File: rtl/dfp_arbiter.sv
// dfp_arbiter: two-client cacheline arbiter feeding a single registered dfp port
// Ports: clk, rst (async active-low); c0_* I-cache client, c1_* D-cache client
//        (addr/read/write/wdata in, rdata/resp out); dfp_* registered request to
//        the cacheline adapter, dfp_rdata/dfp_resp back from it.
module dfp_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic              c0_read,
    input  logic              c0_write,
    input  logic [LINE_W-1:0] c0_wdata,
    output logic [LINE_W-1:0] c0_rdata,
    output logic              c0_resp,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic              c1_read,
    input  logic              c1_write,
    input  logic [LINE_W-1:0] c1_wdata,
    output logic [LINE_W-1:0] c1_rdata,
    output logic              c1_resp,
    output logic [ADDR_W-1:0] dfp_addr,
    output logic              dfp_read,
    output logic              dfp_write,
    output logic [LINE_W-1:0] dfp_wdata,
    input  logic [LINE_W-1:0] dfp_rdata,
    input  logic              dfp_resp
);
    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1, DRAIN} state_t;
    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              read_q, read_d, write_q, write_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              req0, req1, pick1;
    assign req0 = c0_read | c0_write;
    assign req1 = c1_read | c1_write;
    // Client 1 wins when alone, or on a tie when it did not win last (or fixed priority)
    assign pick1 = req1 & (~req0 | (RR_EN ? ~last_q : 1'b1));
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        addr_d  = addr_q;
        read_d  = read_q;
        write_d = write_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: if (req0 | req1) begin
                state_d = pick1 ? BUSY1 : BUSY0;
                last_d  = pick1;
                addr_d  = pick1 ? c1_addr : c0_addr;
                read_d  = pick1 ? c1_read : c0_read;
                write_d = pick1 ? c1_write : c0_write;
                wdata_d = pick1 ? c1_wdata : c0_wdata;
            end
            BUSY0, BUSY1: if (dfp_resp) begin
                read_d  = 1'b0;
                write_d = 1'b0;
                state_d = DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            addr_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            read_q  <= read_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
        end
    end
    assign dfp_addr  = addr_q;
    assign dfp_read  = read_q;
    assign dfp_write = write_q;
    assign dfp_wdata = wdata_q;
    assign c0_rdata  = dfp_rdata;
    assign c1_rdata  = dfp_rdata;
    // Responses arriving in IDLE/DRAIN are spurious and never reach a client
    assign c0_resp   = (state_q == BUSY0) & dfp_resp;
    assign c1_resp   = (state_q == BUSY1) & dfp_resp;
endmodule

// File: tb/tb_dfp_arbiter.sv
// tb_dfp_arbiter: scoreboard bench for dfp_arbiter, round-robin and fixed-priority instances
module tb_dfp_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sel = 1'b0;
    logic [31:0]  c0_addr = '0, c1_addr = '0;
    logic         c0_read = 0, c0_write = 0, c1_read = 0, c1_write = 0;
    logic [255:0] c0_wdata = '0, c1_wdata = '0, dfp_rdata = '0;
    logic         dfp_resp = 0;
    logic [255:0] a_c0_rdata, a_c1_rdata, a_dfp_wdata, b_c0_rdata, b_c1_rdata, b_dfp_wdata;
    logic         a_c0_resp, a_c1_resp, a_dfp_read, a_dfp_write;
    logic         b_c0_resp, b_c1_resp, b_dfp_read, b_dfp_write;
    logic [31:0]  a_dfp_addr, b_dfp_addr;
    logic [255:0] c0_rdata, c1_rdata, dfp_wdata;
    logic         c0_resp, c1_resp, dfp_read, dfp_write;
    logic [31:0]  dfp_addr;
    int           vectors = 0, miscompares = 0;
    int           exp_q[$];

    always #5 clk = ~clk;

    dfp_arbiter #(.RR_EN(1'b1)) dut_rr (
        .clk(clk), .rst(rst),
        .c0_addr(c0_addr), .c0_read(c0_read), .c0_write(c0_write), .c0_wdata(c0_wdata),
        .c0_rdata(a_c0_rdata), .c0_resp(a_c0_resp),
        .c1_addr(c1_addr), .c1_read(c1_read), .c1_write(c1_write), .c1_wdata(c1_wdata),
        .c1_rdata(a_c1_rdata), .c1_resp(a_c1_resp),
        .dfp_addr(a_dfp_addr), .dfp_read(a_dfp_read), .dfp_write(a_dfp_write),
        .dfp_wdata(a_dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp)
    );
    dfp_arbiter #(.RR_EN(1'b0)) dut_fx (
        .clk(clk), .rst(rst),
        .c0_addr(c0_addr), .c0_read(c0_read), .c0_write(c0_write), .c0_wdata(c0_wdata),
        .c0_rdata(b_c0_rdata), .c0_resp(b_c0_resp),
        .c1_addr(c1_addr), .c1_read(c1_read), .c1_write(c1_write), .c1_wdata(c1_wdata),
        .c1_rdata(b_c1_rdata), .c1_resp(b_c1_resp),
        .dfp_addr(b_dfp_addr), .dfp_read(b_dfp_read), .dfp_write(b_dfp_write),
        .dfp_wdata(b_dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp)
    );

    assign c0_rdata  = sel ? b_c0_rdata  : a_c0_rdata;
    assign c1_rdata  = sel ? b_c1_rdata  : a_c1_rdata;
    assign c0_resp   = sel ? b_c0_resp   : a_c0_resp;
    assign c1_resp   = sel ? b_c1_resp   : a_c1_resp;
    assign dfp_addr  = sel ? b_dfp_addr  : a_dfp_addr;
    assign dfp_read  = sel ? b_dfp_read  : a_dfp_read;
    assign dfp_write = sel ? b_dfp_write : a_dfp_write;
    assign dfp_wdata = sel ? b_dfp_wdata : a_dfp_wdata;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        c0_read = 0; c0_write = 0; c1_read = 0; c1_write = 0;
        c0_addr = '0; c1_addr = '0; c0_wdata = '0; c1_wdata = '0;
        dfp_resp = 0; dfp_rdata = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 0;
        tick();
        tick();
        rst = 1;
        tick();
    endtask

    // Adapter model: waits for a request, answers one cycle later with rd.
    // who: 0/1 client that pulsed, 2 both, -1 none or timeout.
    task automatic respond_once(input logic [255:0] rd, output int who, output logic [255:0] obs);
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (dfp_read | dfp_write) begin seen = 1; break; end
            tick();
        end
        who = -1;
        obs = '0;
        if (seen) begin
            tick();
            dfp_rdata = rd;
            dfp_resp = 1;
            #1;
            who = (c0_resp && c1_resp) ? 2 : c1_resp ? 1 : c0_resp ? 0 : -1;
            obs = (who == 1) ? c1_rdata : c0_rdata;
            tick();
            dfp_resp = 0;
        end
    endtask

    task automatic test_reset;
        sel = 0;
        clear_inputs();
        rst = 0;
        #2;
        vectors++;
        if ({dfp_read, dfp_write, c0_resp, c1_resp} !== 4'b0 || dfp_addr !== 32'h0 || dfp_wdata !== 256'h0) begin
            miscompares++;
            $display("FAIL reset_state: rd=%b wr=%b r0=%b r1=%b addr=%h, required all zero",
                     dfp_read, dfp_write, c0_resp, c1_resp, dfp_addr);
        end
        tick();
        rst = 1;
        tick();
    endtask

    task automatic test_single_read;
        logic [255:0] a5 = {32{8'hA5}};
        do_reset();
        c0_read = 1; c0_addr = 32'h0000_1040;
        exp_q.push_back(0);
        #1;
        vectors++;
        if (dfp_read !== 1'b0) begin miscompares++; $display("FAIL read_latency: dfp_read=%b required 0", dfp_read); end
        tick();
        vectors++;
        if (dfp_read !== 1'b1 || dfp_write !== 1'b0 || dfp_addr !== 32'h0000_1040) begin
            miscompares++;
            $display("FAIL read_issue: rd=%b wr=%b addr=%h required 1 0 00001040", dfp_read, dfp_write, dfp_addr);
        end
        tick();
        dfp_rdata = a5; dfp_resp = 1;
        #1;
        vectors++;
        if (c0_resp !== 1'b1 || c1_resp !== 1'b0 || c0_rdata !== a5) begin
            miscompares++;
            $display("FAIL read_resp: r0=%b r1=%b rdata=%h required 1 0 %h", c0_resp, c1_resp, c0_rdata, a5);
        end
        vectors++;
        if (exp_q.pop_front() !== 0) begin miscompares++; $display("FAIL read_sb: client 0 required"); end
        tick();
        dfp_resp = 0; c0_read = 0;
        vectors++;
        if (dfp_read !== 1'b0 || c0_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL read_clear: dfp_read=%b c0_resp=%b required 0 0", dfp_read, c0_resp);
        end
        tick();
        tick();
    endtask

    task automatic test_write_c1;
        logic [255:0] wd = {8{32'h0123_4567}};
        int who;
        logic [255:0] obs;
        do_reset();
        c1_write = 1; c1_wdata = wd; c1_addr = 32'h8000_0020;
        exp_q.push_back(1);
        tick();
        vectors++;
        if (dfp_write !== 1'b1 || dfp_read !== 1'b0 || dfp_addr !== 32'h8000_0020 || dfp_wdata !== wd) begin
            miscompares++;
            $display("FAIL write_issue: wr=%b rd=%b addr=%h wdata=%h required 1 0 80000020 %h",
                     dfp_write, dfp_read, dfp_addr, dfp_wdata, wd);
        end
        c1_wdata = '1; c1_addr = 32'hFFFF_FFFF;
        tick();
        vectors++;
        if (dfp_addr !== 32'h8000_0020 || dfp_wdata !== wd) begin
            miscompares++;
            $display("FAIL write_hold: addr=%h required 80000020", dfp_addr);
        end
        respond_once(256'h0, who, obs);
        c1_write = 0;
        vectors++;
        if (who !== exp_q.pop_front()) begin miscompares++; $display("FAIL write_resp: client=%0d required 1", who); end
        c0_read = 1; c0_addr = 32'h44;
        vectors++;
        if (dfp_write !== 1'b0 || dfp_read !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_low: wr=%b rd=%b required 0 0", dfp_write, dfp_read);
        end
        tick();
        vectors++;
        if (dfp_read !== 1'b0) begin miscompares++; $display("FAIL drain_gap: dfp_read=%b required 0", dfp_read); end
        tick();
        vectors++;
        if (dfp_read !== 1'b1 || dfp_addr !== 32'h44) begin
            miscompares++;
            $display("FAIL after_drain: rd=%b addr=%h required 1 00000044", dfp_read, dfp_addr);
        end
        exp_q.push_back(0);
        respond_once(256'h0, who, obs);
        c0_read = 0;
        vectors++;
        if (who !== exp_q.pop_front()) begin miscompares++; $display("FAIL after_drain_resp: client=%0d required 0", who); end
        tick();
    endtask

    task automatic test_round_robin;
        int who;
        logic [255:0] obs, rd;
        sel = 0;
        do_reset();
        c0_read = 1; c0_addr = 32'h100; c1_read = 1; c1_addr = 32'h200;
        for (int i = 0; i < 6; i++) exp_q.push_back(i % 2);
        for (int i = 0; i < 6; i++) begin
            rd = {8{$urandom}};
            respond_once(rd, who, obs);
            vectors++;
            if (who !== exp_q[0] || obs !== rd) begin
                miscompares++;
                $display("FAIL rr_order[%0d]: client=%0d rdata=%h required client=%0d rdata=%h", i, who, obs, exp_q[0], rd);
            end
            void'(exp_q.pop_front());
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_fixed_priority;
        int who;
        logic [255:0] obs, rd;
        sel = 1;
        do_reset();
        c0_read = 1; c0_addr = 32'h300; c1_read = 1; c1_addr = 32'h400;
        exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(0);
        for (int i = 0; i < 4; i++) begin
            rd = {8{$urandom}};
            respond_once(rd, who, obs);
            if (i == 2) c1_read = 0;
            vectors++;
            if (who !== exp_q[0] || obs !== rd) begin
                miscompares++;
                $display("FAIL fixed_order[%0d]: client=%0d required %0d", i, who, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        clear_inputs();
        tick();
        tick();
        sel = 0;
    endtask

    task automatic test_async_reset;
        int who;
        logic [255:0] obs;
        sel = 0;
        do_reset();
        c1_read = 1; c1_addr = 32'h500;
        tick();
        vectors++;
        if (dfp_read !== 1'b1) begin miscompares++; $display("FAIL busy1_issue: dfp_read=%b required 1", dfp_read); end
        rst = 0; c1_read = 0;
        #1;
        vectors++;
        if (dfp_read !== 1'b0 || dfp_write !== 1'b0 || dfp_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset: rd=%b wr=%b addr=%h required 0 0 0", dfp_read, dfp_write, dfp_addr);
        end
        #3;
        rst = 1;
        tick();
        dfp_resp = 1;
        #1;
        vectors++;
        if (c0_resp !== 1'b0 || c1_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL stale_resp: r0=%b r1=%b required 0 0", c0_resp, c1_resp);
        end
        tick();
        dfp_resp = 0;
        c0_read = 1; c1_read = 1;
        exp_q.push_back(0); exp_q.push_back(1);
        for (int i = 0; i < 2; i++) begin
            respond_once(256'h0, who, obs);
            if (i == 0) c0_read = 0;
            vectors++;
            if (who !== exp_q[0]) begin
                miscompares++;
                $display("FAIL post_reset_tie[%0d]: client=%0d required %0d", i, who, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_spurious;
        sel = 0;
        do_reset();
        dfp_resp = 1; dfp_rdata = '1;
        #1;
        vectors++;
        if (c0_resp !== 1'b0 || c1_resp !== 1'b0) begin
            miscompares++;
            $display("FAIL spurious_resp: r0=%b r1=%b required 0 0", c0_resp, c1_resp);
        end
        tick();
        dfp_resp = 0;
        c0_read = 1; c0_addr = 32'h600;
        vectors++;
        if (dfp_read !== 1'b0 || dfp_write !== 1'b0) begin
            miscompares++;
            $display("FAIL spurious_idle: rd=%b wr=%b required 0 0", dfp_read, dfp_write);
        end
        tick();
        vectors++;
        if (dfp_read !== 1'b1 || dfp_addr !== 32'h600) begin
            miscompares++;
            $display("FAIL spurious_then_req: rd=%b addr=%h required 1 00000600", dfp_read, dfp_addr);
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_c1();
        test_round_robin();
        test_fixed_priority();
        test_async_reset();
        test_spurious();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
